// File: rtl/rhd_spi_responder.sv
// rhd_spi_responder: SPI command responder with a 2-frame result pipeline, register file and convert counter.
// Optional macro RHD_RESP_DDR_EN: also drive ~result on sclk rising edges (32 bits per frame).
module rhd_spi_responder #(
  parameter logic [7:0]  CHIP_ID     = 8'd4,
  parameter int unsigned NUM_RW_REGS = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic        sclk,
  input  logic        copi,
  output logic        cipo,
  output logic [31:0] frame_count,
  output logic [15:0] frame_err_count,
  output logic [15:0] last_cmd
);

`ifdef RHD_RESP_DDR_EN
  localparam int unsigned TW = 32;
`else
  localparam int unsigned TW = 16;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]    csn_sy, sclk_sy, copi_sy;
  logic          csn_q, sclk_q;
  logic [1:0]    rst_age;
  logic          csn_fall, csn_rise, sclk_rise, sclk_fall, tx_adv, pend, start;
  logic [TW-1:0] pipe0, pipe1, tx_shift, result, load_vec;
  logic [15:0]   rx_shift, res_a;
  logic [4:0]    bit_cnt;
  logic [9:0]    sample_cnt;
  logic [7:0]    regs [NUM_RW_REGS];
  logic [7:0]    rdval;

  always_ff @(posedge clk) begin
    if (rst) begin
      csn_sy  <= '1;
      sclk_sy <= '0;
      copi_sy <= '0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      rst_age <= '0;
    end else begin
      csn_sy  <= {csn_sy[0], csn};
      sclk_sy <= {sclk_sy[0], sclk};
      copi_sy <= {copi_sy[0], copi};
      csn_q   <= csn_sy[1];
      sclk_q  <= sclk_sy[1];
      if (rst_age != 2'd3) rst_age <= rst_age + 2'd1;
    end
  end

  // Edge history holds reset levels for 3 cycles; a csn held low across reset must not look like a fall.
  assign csn_fall  = (rst_age == 2'd3) & csn_q & ~csn_sy[1];
  assign csn_rise  = ~csn_q & csn_sy[1];
  assign sclk_rise = ~sclk_q & sclk_sy[1];
  assign sclk_fall = sclk_q & ~sclk_sy[1];
  assign start     = csn_fall | pend;
`ifdef RHD_RESP_DDR_EN
  assign tx_adv = sclk_rise | sclk_fall;
`else
  assign tx_adv = sclk_fall;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (csn_rise) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdval    = '0;
    res_a    = '0;
    result   = '0;
    load_vec = '0;
    case (rx_shift[13:8])
      6'd40:   rdval = 8'h49;
      6'd41:   rdval = 8'h4E;
      6'd42:   rdval = 8'h54;
      6'd43:   rdval = 8'h41;
      6'd44:   rdval = 8'h4E;
      6'd63:   rdval = CHIP_ID;
      default: rdval = '0;
    endcase
    for (int unsigned i = 0; i < NUM_RW_REGS; i++)
      if (rx_shift[13:8] == 6'(i)) rdval = regs[i];
    case (rx_shift[15:14])
      2'b00:   res_a = {rx_shift[13:8], sample_cnt};
      2'b01:   res_a = '0;
      2'b10:   res_a = {8'hFF, rx_shift[7:0]};
      default: res_a = {8'h00, rdval};
    endcase
`ifdef RHD_RESP_DDR_EN
    result = {res_a, ~res_a};
    // Interleave so the MSB-first shift yields A15, B15, A14, B14, ... A0, B0.
    for (int unsigned i = 0; i < 16; i++) begin
      load_vec[2*i+1] = pipe1[16+i];
      load_vec[2*i]   = pipe1[i];
    end
`else
    result   = res_a;
    load_vec = pipe1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cipo            <= 1'b0;
      pend            <= 1'b0;
      pipe0           <= '0;
      pipe1           <= '0;
      tx_shift        <= '0;
      rx_shift        <= '0;
      bit_cnt         <= '0;
      sample_cnt      <= '0;
      frame_count     <= '0;
      frame_err_count <= '0;
      last_cmd        <= '0;
      for (int unsigned i = 0; i < NUM_RW_REGS; i++) regs[i] <= '0;
    end else begin
      pend <= (state == DONE) && csn_fall;
      case (state)
        IDLE: if (start) begin
          bit_cnt  <= '0;
          tx_shift <= load_vec;
          cipo     <= load_vec[TW-1];
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[14:0], copi_sy[1]};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end
          // Refilling with the last bit makes cipo hold it once the word is exhausted.
          if (tx_adv) begin
            tx_shift <= {tx_shift[TW-2:0], tx_shift[0]};
            cipo     <= tx_shift[TW-2];
          end
        end
        DONE: begin
          if (bit_cnt == 5'd16) begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++)
              if (rx_shift[15:14] == 2'b10 && rx_shift[13:8] == 6'(i)) regs[i] <= rx_shift[7:0];
            if (rx_shift[15:14] == 2'b00) sample_cnt <= sample_cnt + 10'd1;
            pipe1       <= pipe0;
            pipe0       <= result;
            frame_count <= frame_count + 32'd1;
            last_cmd    <= rx_shift;
          end else if (frame_err_count != '1) begin
            frame_err_count <= frame_err_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
